// File: rtl/memory_stage.sv
// Y86-64 memory stage: data memory access, memory status and the M->W register.
// State changes on the falling clock edge; reset is synchronous active-high.
module memory_stage #(
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  m_ifun,
    input  logic        m_cnd,
    input  logic [63:0] m_valE,
    input  logic [63:0] m_valA,
    input  logic [63:0] m_valP,
    input  logic [3:0]  m_dstE,
    input  logic [3:0]  m_dstM,
    input  logic [2:0]  M_stat,
    input  logic        W_stall,
    input  logic        W_bubble,
    input  logic        dbg_we,
    input  logic [63:0] dbg_addr,
    input  logic [63:0] dbg_wdata,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic [3:0]  W_icode,
    output logic [2:0]  W_stat,
    output logic [63:0] w_valE,
    output logic [63:0] w_valM,
    output logic [3:0]  w_dstE,
    output logic [3:0]  w_dstM,
    output logic        halted
);

    localparam int AW = $clog2(DMEM_BYTES);
    localparam logic [63:0] LAST = 64'(DMEM_BYTES - 8);

    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_ADR = 3'd3;

    logic [7:0]    mem [DMEM_BYTES];

    logic          mem_read;
    logic          mem_write;
    logic [63:0]   addr;
    logic [63:0]   wdata;
    logic [63:0]   rdata;
    logic          dmem_error;
    logic          do_write;
    logic          dbg_ok;
    logic [AW-1:0] base;
    logic [AW-1:0] dbg_base;
    logic [3:0]    dst_e;
    logic          unused_ifun;

    assign unused_ifun = ^m_ifun;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 64'd0;
        wdata     = m_valA;
        case (M_icode)
            I_RMMOVQ, I_PUSHQ: begin
                mem_write = 1'b1;
                addr      = m_valE;
            end
            I_CALL: begin
                mem_write = 1'b1;
                addr      = m_valE;
                wdata     = m_valP;
            end
            I_MRMOVQ: begin
                mem_read = 1'b1;
                addr     = m_valE;
            end
            I_RET, I_POPQ: begin
                mem_read = 1'b1;
                addr     = m_valA;
            end
            default: ;
        endcase
    end

    // Full 64-bit compare: huge addresses must not wrap into range.
    assign dmem_error = (mem_read || mem_write) && (addr > LAST);
    assign base       = addr[AW-1:0];
    assign dbg_ok     = dbg_we && (dbg_addr <= LAST);
    assign dbg_base   = dbg_addr[AW-1:0];

    always_comb begin
        rdata = 64'd0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    assign m_valM = (mem_read && !dmem_error) ? rdata : 64'd0;
    assign m_stat = dmem_error ? S_ADR : M_stat;

    // Anything excepting, or queued behind an exception, leaves memory alone.
    assign do_write = mem_write && !dmem_error && !rst && !halted
                      && (m_stat == S_AOK) && (W_stat == S_AOK);

    assign dst_e = (M_icode == I_RRMOVQ && !m_cnd) ? R_NONE : m_dstE;

    // Debug port is written second so it owns any overlapping bytes.
    always_ff @(negedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= wdata[8*i +: 8];
            end
        end
        if (dbg_ok) begin
            for (int i = 0; i < 8; i++) begin
                mem[dbg_base + AW'(i)] <= dbg_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            W_icode <= I_NOP;
            W_stat  <= S_AOK;
            w_valE  <= 64'd0;
            w_valM  <= 64'd0;
            w_dstE  <= R_NONE;
            w_dstM  <= R_NONE;
            halted  <= 1'b0;
        end else if (halted || W_stall) begin
            W_icode <= W_icode;
        end else if (W_bubble) begin
            W_icode <= I_NOP;
            W_stat  <= S_AOK;
            w_valE  <= 64'd0;
            w_valM  <= 64'd0;
            w_dstE  <= R_NONE;
            w_dstM  <= R_NONE;
        end else begin
            W_icode <= M_icode;
            W_stat  <= m_stat;
            w_valE  <= m_valE;
            w_valM  <= m_valM;
            w_dstE  <= dst_e;
            w_dstM  <= m_dstM;
            halted  <= (m_stat != S_AOK);
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a cycle-tagged expectation queue.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  M_icode = 4'd1;
    logic [3:0]  m_ifun = 4'd0;
    logic        m_cnd = 1'b0;
    logic [63:0] m_valE = 64'd0;
    logic [63:0] m_valA = 64'd0;
    logic [63:0] m_valP = 64'd0;
    logic [3:0]  m_dstE = 4'hF;
    logic [3:0]  m_dstM = 4'hF;
    logic [2:0]  M_stat = 3'd1;
    logic        W_stall = 1'b0;
    logic        W_bubble = 1'b0;
    logic        dbg_we = 1'b0;
    logic [63:0] dbg_addr = 64'd0;
    logic [63:0] dbg_wdata = 64'd0;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic [3:0]  W_icode;
    logic [2:0]  W_stat;
    logic [63:0] w_valE;
    logic [63:0] w_valM;
    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic        halted;

    memory_stage #(.DMEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .M_icode(M_icode), .m_ifun(m_ifun), .m_cnd(m_cnd),
        .m_valE(m_valE), .m_valA(m_valA), .m_valP(m_valP),
        .m_dstE(m_dstE), .m_dstM(m_dstM), .M_stat(M_stat),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .m_valM(m_valM), .m_stat(m_stat),
        .W_icode(W_icode), .W_stat(W_stat),
        .w_valE(w_valE), .w_valM(w_valM),
        .w_dstE(w_dstE), .w_dstM(w_dstM), .halted(halted)
    );

    always #5 clk = ~clk;

    // Output selectors: 0-1 are combinational, 2-8 are W register fields.
    localparam int VALM = 0, MSTAT = 1, WICODE = 2, WSTAT = 3, WVALE = 4;
    localparam int WVALM = 5, WDSTE = 6, WDSTM = 7, HALT = 8;

    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] val;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            VALM:    return m_valM;
            MSTAT:   return 64'(m_stat);
            WICODE:  return 64'(W_icode);
            WSTAT:   return 64'(W_stat);
            WVALE:   return w_valE;
            WVALM:   return w_valM;
            WDSTE:   return 64'(w_dstE);
            WDSTM:   return 64'(w_dstM);
            default: return 64'(halted);
        endcase
    endfunction

    // Combinational results are due this cycle, W fields after the next falling edge.
    task automatic chk(input string nm, input int sel, input logic [63:0] v);
        exp_t e;
        e.cyc = (sel <= MSTAT) ? cyc : cyc + 1;
        e.sel = sel;
        e.val = v;
        e.nm  = nm;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [63:0] a;
        forever begin
            @(posedge clk);
            #3;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_cmp++;
                a = actual(e.sel);
                if (e.cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: check missed its cycle %0d (now %0d)", e.nm, e.cyc, cyc);
                end else if (a !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h expected %0h", e.nm, a, e.val);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                         input logic [63:0] vp, input logic [3:0] de, input logic [3:0] dm,
                         input logic c);
        @(posedge clk);
        #1;
        M_icode  = ic;
        m_valE   = ve;
        m_valA   = va;
        m_valP   = vp;
        m_dstE   = de;
        m_dstM   = dm;
        m_cnd    = c;
        M_stat   = 3'd1;
        rst      = 1'b0;
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        dbg_we   = 1'b0;
    endtask

    task automatic dbg(input logic [63:0] a, input logic [63:0] d);
        dbg_we    = 1'b1;
        dbg_addr  = a;
        dbg_wdata = d;
    endtask

    initial begin : stim
        // Reset with preloads; nop inputs must not reach W.
        issue(4'd1, 64'h55, 0, 0, 4'd2, 4'd3, 1'b1);
        rst = 1'b1;
        dbg(64'h100, 64'h1122334455667788);
        chk("rst_icode", WICODE, 1);
        chk("rst_stat", WSTAT, 1);
        chk("rst_vale", WVALE, 0);
        chk("rst_valm", WVALM, 0);
        chk("rst_dste", WDSTE, 15);
        chk("rst_dstm", WDSTM, 15);
        chk("rst_halt", HALT, 0);
        issue(4'd1, 0, 0, 0, 4'hF, 4'hF, 1'b0);
        rst = 1'b1;
        dbg(64'h208, 64'h0);

        issue(4'd5, 64'h100, 0, 0, 4'hF, 4'd3, 1'b0);
        chk("mr100_valm", VALM, 64'h1122334455667788);
        chk("mr100_stat", MSTAT, 1);
        chk("mr100_wvalm", WVALM, 64'h1122334455667788);
        chk("mr100_wdstm", WDSTM, 3);
        chk("mr100_wstat", WSTAT, 1);
        chk("mr100_wicode", WICODE, 5);

        issue(4'd4, 64'h200, 64'hDEADBEEF, 0, 4'hF, 4'hF, 1'b0);
        chk("rm200_valm", VALM, 0);
        chk("rm200_wvale", WVALE, 64'h200);
        issue(4'd5, 64'h200, 0, 0, 4'hF, 4'd4, 1'b0);
        chk("mr200_valm", VALM, 64'hDEADBEEF);
        issue(4'd5, 64'h201, 0, 0, 4'hF, 4'd4, 1'b0);
        chk("mr201_bytes", VALM, 64'h0000000000DEADBE);

        issue(4'd8, 64'h3F8, 64'h999, 64'h40, 4'd4, 4'hF, 1'b0);
        chk("call_stat", MSTAT, 1);
        issue(4'd9, 64'h400, 64'h3F8, 0, 4'd4, 4'hF, 1'b0);
        chk("ret_valm", VALM, 64'h40);
        chk("ret_wvale", WVALE, 64'h400);
        chk("ret_wvalm", WVALM, 64'h40);

        issue(4'd2, 64'h7, 0, 0, 4'd5, 4'hF, 1'b0);
        chk("cmov_nt_dste", WDSTE, 15);
        chk("cmov_nt_vale", WVALE, 64'h7);
        issue(4'd2, 64'h7, 0, 0, 4'd5, 4'hF, 1'b1);
        chk("cmov_t_dste", WDSTE, 5);
        issue(4'd6, 64'h66, 0, 0, 4'd6, 4'hF, 1'b0);
        chk("opq_dste", WDSTE, 6);

        issue(4'd6, 64'h77, 0, 0, 4'd7, 4'hF, 1'b0);
        W_stall = 1'b1;
        chk("stall_icode", WICODE, 6);
        chk("stall_vale", WVALE, 64'h66);
        chk("stall_dste", WDSTE, 6);
        issue(4'd6, 64'h88, 0, 0, 4'd8, 4'd8, 1'b0);
        W_bubble = 1'b1;
        chk("bubble_icode", WICODE, 1);
        chk("bubble_dste", WDSTE, 15);
        chk("bubble_dstm", WDSTM, 15);
        chk("bubble_vale", WVALE, 0);
        issue(4'd5, 64'h100, 0, 0, 4'hF, 4'd9, 1'b0);
        W_stall  = 1'b1;
        W_bubble = 1'b1;
        chk("both_icode", WICODE, 1);
        chk("both_dstm", WDSTM, 15);

        issue(4'd4, 64'h100, 64'hBAD, 0, 4'hF, 4'hF, 1'b0);
        W_bubble = 1'b0;
        rst = 1'b1;
        chk("rstwr_icode", WICODE, 1);
        chk("rstwr_vale", WVALE, 0);
        issue(4'd5, 64'h100, 0, 0, 4'hF, 4'd3, 1'b0);
        chk("rstwr_mem", VALM, 64'h1122334455667788);

        issue(4'd5, 64'h3F8, 0, 0, 4'hF, 4'd3, 1'b0);
        chk("edge_ok_stat", MSTAT, 1);
        chk("edge_ok_valm", VALM, 64'h40);

        issue(4'd4, 64'h300, 64'h123456789ABCDEF0, 0, 4'hF, 4'hF, 1'b0);
        issue(4'd5, 64'h300, 0, 0, 4'hF, 4'd3, 1'b0);
        chk("raw_valm", VALM, 64'h123456789ABCDEF0);

        issue(4'd4, 64'h3FC, 64'hFFFFFFFFFFFFFFFF, 0, 4'hF, 4'hF, 1'b0);
        chk("oor_stat", MSTAT, 3);
        chk("oor_valm", VALM, 0);
        chk("oor_wstat", WSTAT, 3);
        chk("oor_halt", HALT, 1);
        chk("oor_wicode", WICODE, 4);
        issue(4'd5, 64'h3F8, 0, 0, 4'hF, 4'd2, 1'b0);
        chk("oor_nowrite", VALM, 64'h40);
        chk("frz_wicode", WICODE, 4);
        chk("frz_wstat", WSTAT, 3);
        chk("frz_vale", WVALE, 64'h3FC);
        chk("frz_dstm", WDSTM, 15);
        chk("frz_halt", HALT, 1);
        issue(4'd4, 64'h300, 64'hAAA, 0, 4'hF, 4'hF, 1'b0);
        issue(4'd5, 64'h300, 0, 0, 4'hF, 4'd3, 1'b0);
        chk("halt_nowrite", VALM, 64'h123456789ABCDEF0);
        issue(4'd5, 64'hFFFFFFFFFFFFFFFC, 0, 0, 4'hF, 4'd3, 1'b0);
        chk("wrap_stat", MSTAT, 3);
        chk("wrap_valm", VALM, 0);

        issue(4'd1, 0, 0, 0, 4'hF, 4'hF, 1'b0);
        rst = 1'b1;
        chk("rst2_halt", HALT, 0);
        chk("rst2_stat", WSTAT, 1);
        issue(4'd0, 0, 0, 0, 4'hF, 4'hF, 1'b0);
        M_stat = 3'd2;
        chk("hlt_mstat", MSTAT, 2);
        chk("hlt_wstat", WSTAT, 2);
        chk("hlt_halt", HALT, 1);

        issue(4'd1, 0, 0, 0, 4'hF, 4'hF, 1'b0);
        repeat (3) @(posedge clk);
        #4;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Y86-64 pipeline memory stage; consumes the execute-to-memory pipeline register (M_icode, m_valE, m_valA, m_valP, m_dstE, m_dstM, m_cnd, M_stat).
- Performs data-memory reads and writes, computes the memory-stage status, and drives the memory-to-writeback pipeline register (W_*).
- Exports m_valM and m_stat combinationally for forwarding and pipeline control.
- Holds the byte-addressed little-endian data memory and a sticky halt/exception freeze.

Parameters:
- DMEM_BYTES, 1024, data memory size in bytes; valid 8-byte access requires addr+7 < DMEM_BYTES.

Ports:
- clk  input  1  clock; all state updates on negedge clk (pipeline convention).
- rst  input  1  synchronous active-high reset, sampled on negedge clk.
- M_icode  input  4  instruction code in memory stage.
- m_ifun  input  4  function code.
- m_cnd  input  1  condition result from execute.
- m_valE  input  64  ALU result / effective address.
- m_valA  input  64  rA value / stack pointer for ret and popq.
- m_valP  input  64  return address for call.
- m_dstE  input  4  destination register for valE (15 = none).
- m_dstM  input  4  destination register for valM (15 = none).
- M_stat  input  3  upstream status (1 AOK, 2 HLT, 3 ADR, 4 INS).
- W_stall  input  1  hold W register.
- W_bubble  input  1  load nop into W register.
- dbg_we  input  1  testbench preload write enable.
- dbg_addr  input  64  preload byte address.
- dbg_wdata  input  64  preload 8-byte little-endian data.
- m_valM  output  64  read data (combinational).
- m_stat  output  3  memory-stage status (combinational).
- W_icode  output  4  writeback icode.
- W_stat  output  3  writeback status.
- w_valE  output  64  writeback valE.
- w_valM  output  64  writeback valM.
- w_dstE  output  4  writeback dstE.
- w_dstM  output  4  writeback dstM.
- halted  output  1  sticky: W_stat is non-AOK.

Behaviour:
- Address select: icode 4, 5, 8, 10 use m_valE; icode 9, 11 use m_valA; all others perform no access.
- Read (icode 5, 9, 11): m_valM = mem[addr+7..addr], little-endian, combinational. Otherwise m_valM = 0.
- Write (icode 4, 10): data m_valA. Write (icode 8): data m_valP. 8 bytes written at negedge clk.
- dmem_error: access active and addr > DMEM_BYTES-8, unsigned 64-bit compare so no wrap-around.
- m_stat = 3 (ADR) if dmem_error, else M_stat.
- On dmem_error, no bytes are written and m_valM = 0.
- Write suppression: no write when m_stat != 1, W_stat != 1, or halted = 1. Suppression means an excepting instruction and everything behind it cannot modify memory.
- Conditional move: icode 2 with m_cnd = 0 forces the registered w_dstE to 15. All other icodes pass m_dstE unchanged.
- W register update at negedge clk, priority order:
  1. rst: W_icode = 1, W_stat = 1, w_valE = 0, w_valM = 0, w_dstE = 15, w_dstM = 15, halted = 0.
  2. halted: hold all W outputs.
  3. W_stall: hold.
  4. W_bubble: load the reset values (halted unchanged).
  5. Otherwise: W_icode = M_icode, W_stat = m_stat, w_valE = m_valE, w_valM = m_valM, w_dstE (gated as above), w_dstM = m_dstM.
- Same-cycle W_stall and W_bubble: stall wins.
- halted is set on the edge that loads W_stat != 1. It clears only on rst.
- rst mid-operation: a pending memory write in the same cycle is suppressed.
- Memory contents are not cleared by rst.
- dbg_we: writes dbg_wdata at dbg_addr at negedge clk.
  - Allowed during rst.
  - Out-of-range dbg_addr is ignored.
  - Same-cycle conflict with a pipeline write: dbg wins on overlapping bytes.
- Read-after-write to the same address in consecutive instructions: the read sees the new data, because the write commits at the edge before the read instruction arrives.
- Initial memory content is undefined unless preloaded.

Test Plan:
- Preload mem[0x100] = 0x1122334455667788 via dbg. Issue M_icode = 5, m_valE = 0x100, m_dstM = 3 -> m_valM = 0x1122334455667788 same cycle; next edge w_valM equals it, w_dstM = 3, W_stat = 1.
- rmmovq: M_icode = 4, m_valE = 0x200, m_valA = 0xDEADBEEF. Then mrmovq from 0x200 -> m_valM = 0xDEADBEEF. Byte 0x200 = 0xEF, byte 0x207 = 0x00.
- call then ret: call with m_valE = 0x3F8, m_valP = 0x40 writes 0x40 at 0x3F8. Then ret with m_valA = 0x3F8 -> m_valM = 0x40.
- Out of range: M_icode = 4, m_valE = 0x3FC (DMEM_BYTES = 1024) -> m_stat = 3, no bytes 0x3FC..0x3FF changed. Next edge W_stat = 3, halted = 1; later inputs leave W_* frozen until rst.
- cmov not taken: M_icode = 2, m_cnd = 0, m_dstE = 5 -> w_dstE = 15. With m_cnd = 1 -> w_dstE = 5.
- Controls: W_stall = 1 holds W_* one cycle. W_bubble = 1 gives W_icode = 1, w_dstE = w_dstM = 15. Both asserted -> hold. rst asserted with pending rmmovq -> W at reset values, memory unchanged.
